// File: rtl/sha_mine_pkg.sv
// Shared types and constants for the nonce search controller.
// State encoding, data widths and default hash-stage latency.
package sha_mine_pkg;

    localparam int WORD_W           = 32;
    localparam int DIGEST_W         = 256;
    localparam int PIPE_LAT_DEFAULT = 65;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FOUND
    } state_t;

endpackage

// File: rtl/tag_pipe.sv
// Fixed-depth delay line of {valid, data} tags that tracks the hash stage.
// Flush or reset clears every valid bit; the data bits are left alone.
module tag_pipe #(
    parameter int DEPTH = 65,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Valid bits shift one stage per cycle; flush wipes them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], in_valid};
        end
    end

    // Tag payload follows the valid bits; it is only meaningful when valid.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/nonce_search_ctrl.sv
// Issues consecutive nonces to a fixed-latency hash stage and reports
// the lowest-index nonce whose digest falls below the target.
module nonce_search_ctrl
    import sha_mine_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DIGEST_W-1:0] base_nonce,
    input  logic [DIGEST_W-1:0] target,
    input  logic [WORD_W-1:0]   max_count,
    output logic [DIGEST_W-1:0] hash_nonce,
    input  logic [DIGEST_W-1:0] hash_digest,
    output logic                found_valid,
    input  logic                found_ready,
    output logic [DIGEST_W-1:0] found_nonce,
    output logic [DIGEST_W-1:0] found_digest,
    output logic                busy,
    output logic                done,
    output logic                exhausted
);

    state_t              state, state_n;
    logic [WORD_W-1:0]   idx, max_q;
    logic [DIGEST_W-1:0] base_q, target_q;
    logic                cmp_valid, hit_q;
    logic                tag_v, pipe_any;
    logic [WORD_W-1:0]   tag_idx;
    logic                issue, load, flush, keep, hit_now;
    logic                drain_done, ack_done;

    assign busy  = (state != IDLE);
    assign load  = (state == IDLE) && (state_n == RUN);
    assign issue = (state == RUN) && (idx < max_q) && !hit_q && !abort;
    assign keep  = (state_n == RUN) || (state_n == DRAIN);
    assign flush = abort
                 || (((state == FOUND) || (state == DRAIN))
                     && (state_n != state));
    assign hit_now = ((state == RUN) || (state == DRAIN)) && keep
                   && tag_v && !hit_q && (hash_digest < target_q);

    tag_pipe #(
        .DEPTH (PIPE_LAT),
        .W     (WORD_W)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (issue),
        .in_data   (idx),
        .out_valid (tag_v),
        .out_data  (tag_idx),
        .any_valid (pipe_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_n    = state;
        drain_done = 1'b0;
        ack_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (hit_q)               state_n = FOUND;
                else if (idx >= max_q)   state_n = DRAIN;
            end
            DRAIN: begin
                if (hit_q) begin
                    state_n = FOUND;
                end else if (!pipe_any && !cmp_valid) begin
                    state_n    = IDLE;
                    drain_done = 1'b1;
                end
            end
            FOUND: begin
                if (found_valid && found_ready) begin
                    state_n  = IDLE;
                    ack_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n    = IDLE;
            drain_done = 1'b0;
            ack_done   = 1'b0;
        end
    end

    // Search datapath: issue, compare stage, result capture and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            max_q        <= '0;
            base_q       <= '0;
            target_q     <= '0;
            hash_nonce   <= '0;
            cmp_valid    <= 1'b0;
            hit_q        <= 1'b0;
            found_valid  <= 1'b0;
            found_nonce  <= '0;
            found_digest <= '0;
            done         <= 1'b0;
            exhausted    <= 1'b0;
        end else begin
            if (load) begin
                base_q   <= base_nonce;
                target_q <= target;
                max_q    <= max_count;
                idx      <= '0;
            end
            if (issue) begin
                hash_nonce <= base_q + DIGEST_W'(idx);
                idx        <= idx + WORD_W'(1);
            end
            cmp_valid <= keep && tag_v;
            hit_q     <= hit_now;
            if (hit_now) begin
                found_nonce  <= base_q + DIGEST_W'(tag_idx);
                found_digest <= hash_digest;
            end
            found_valid <= (state_n == FOUND);
            done        <= drain_done || ack_done;
            if (load || ack_done) exhausted <= 1'b0;
            else if (drain_done)  exhausted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl with a behavioural hash
// stage and a first-hit reference model.
module tb_nonce_search_ctrl;

    localparam int P = 65;
    localparam logic [255:0] KEY =
        256'h3c6e_f372_a54f_f53a_510e_527f_9b05_688c_1f83_d9ab_5be0_cd19_6a09_e667_bb67_ae85;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         found_ready = 1'b0;
    logic [255:0] base_nonce = '0;
    logic [255:0] target = '0;
    logic [31:0]  max_count = '0;
    logic [255:0] hash_nonce, hash_digest, found_nonce, found_digest;
    logic         found_valid, busy, done, exhausted;

    int checks = 0;
    int failures = 0;

    nonce_search_ctrl #(.PIPE_LAT(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .base_nonce   (base_nonce),
        .target       (target),
        .max_count    (max_count),
        .hash_nonce   (hash_nonce),
        .hash_digest  (hash_digest),
        .found_valid  (found_valid),
        .found_ready  (found_ready),
        .found_nonce  (found_nonce),
        .found_digest (found_digest),
        .busy         (busy),
        .done         (done),
        .exhausted    (exhausted)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] fhash(input logic [255:0] n);
        return {n[100:0], n[255:101]} ^ KEY;
    endfunction

    function automatic int first_hit(input logic [255:0] b,
                                     input logic [255:0] t,
                                     input int m);
        for (int i = 0; i < m; i++)
            if (fhash(b + 256'(i)) < t) return i;
        return -1;
    endfunction

    // Hash stage model: digest of the nonce presented in cycle c is
    // visible in cycle c+P-1 and so is sampled at edge c+P.
    logic [255:0] hp [P-1];
    always @(posedge clk) begin
        hp[0] <= hash_nonce;
        for (int k = 1; k < P - 1; k++) hp[k] <= hp[k-1];
    end
    assign hash_digest = fhash(hp[P-2]);

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Start is sampled at the posedge that the bench calls edge 0.
    task automatic kick(input logic [255:0] b, input logic [255:0] t,
                        input logic [31:0] m);
        @(negedge clk);
        base_nonce = b;
        target     = t;
        max_count  = m;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic step_until(input int from, input int upto,
                              output int at);
        at = -1;
        for (int e = from; e <= upto; e++) begin
            @(posedge clk); #1;
            if (found_valid || done) begin
                at = e;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (exhausted !== 1'b0) begin failures++;
            $display("FAIL reset_exhausted got=%0b exp=0", exhausted); end
        checks++; if (found_valid !== 1'b0) begin failures++;
            $display("FAIL reset_found_valid got=%0b exp=0", found_valid); end
        checks++; if (hash_nonce !== '0) begin failures++;
            $display("FAIL reset_hash_nonce got=%0h exp=0", hash_nonce); end
        checks++; if (found_nonce !== '0 || found_digest !== '0) begin failures++;
            $display("FAIL reset_found_data got=%0h/%0h exp=0/0", found_nonce, found_digest); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset got=%0b exp=0", busy); end
    endtask

    task automatic test_first_hit();
        int at;
        int ei;
        ei = first_hit('0, '1, 10);
        kick('0, '1, 32'd10);
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL fh_busy got=%0b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (hash_nonce !== '0) begin failures++;
            $display("FAIL fh_nonce_edge1 got=%0h exp=0", hash_nonce); end
        step_until(2, P + 20, at);
        checks++; if (at !== 2 + P + ei) begin failures++;
            $display("FAIL fh_edge got=%0d exp=%0d", at, 2 + P + ei); end
        checks++; if (found_valid !== 1'b1 || found_nonce !== 256'(ei)) begin failures++;
            $display("FAIL fh_nonce got=%0b/%0h exp=1/%0h", found_valid, found_nonce, ei); end
        checks++; if (found_digest !== fhash(256'(ei))) begin failures++;
            $display("FAIL fh_digest got=%0h exp=%0h", found_digest, fhash(256'(ei))); end
        found_ready = 1'b1;
        @(posedge clk); #1;
        found_ready = 1'b0;
        checks++; if ({done, exhausted, busy, found_valid} !== 4'b1000) begin failures++;
            $display("FAIL fh_ack got=%b exp=1000", {done, exhausted, busy, found_valid}); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL fh_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_no_hit();
        int at;
        logic [255:0] en;
        kick(256'd5, '0, 32'd4);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            en = 256'd5 + 256'((e < 4 ? e : 4) - 1);
            checks++; if (hash_nonce !== en) begin failures++;
                $display("FAIL nh_nonce_e%0d got=%0h exp=%0h", e, hash_nonce, en); end
        end
        step_until(7, 4 + P + 20, at);
        checks++; if (at !== 4 + P + 2) begin failures++;
            $display("FAIL nh_done_edge got=%0d exp=%0d", at, 4 + P + 2); end
        checks++; if ({done, exhausted, found_valid} !== 3'b110) begin failures++;
            $display("FAIL nh_flags got=%b exp=110", {done, exhausted, found_valid}); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({done, exhausted, busy} !== 3'b010) begin failures++;
            $display("FAIL nh_hold got=%b exp=010", {done, exhausted, busy}); end
    endtask

    task automatic test_max_zero();
        int at;
        kick(rnd256(), '1, 32'd0);
        checks++; if (exhausted !== 1'b0) begin failures++;
            $display("FAIL mz_exh_clear got=%0b exp=0", exhausted); end
        step_until(1, 20, at);
        checks++; if (at !== 2) begin failures++;
            $display("FAIL mz_edge got=%0d exp=2", at); end
        checks++; if ({done, exhausted, found_valid} !== 3'b110) begin failures++;
            $display("FAIL mz_flags got=%b exp=110", {done, exhausted, found_valid}); end
    endtask

    task automatic test_back_to_back();
        int at;
        int ei;
        int k;
        logic [255:0] b, t;
        b  = rnd256();
        k  = $urandom_range(0, 7);
        t  = fhash(b + 256'(k)) + 256'd1;
        ei = first_hit(b, t, 8);
        kick(b, t, 32'd8);
        step_until(1, P + 30, at);
        checks++; if (at !== 2 + P + ei) begin failures++;
            $display("FAIL bp_edge got=%0d exp=%0d", at, 2 + P + ei); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({found_valid, found_nonce, found_digest}
                !== {1'b1, b + 256'(ei), fhash(b + 256'(ei))}) begin
                failures++;
                $display("FAIL bp_stable_c%0d got=%0b/%0h exp=1/%0h",
                         c, found_valid, found_nonce, b + 256'(ei));
            end
        end
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL bp_no_early_done got=%0b exp=0", done); end
        found_ready = 1'b1;
        @(posedge clk); #1;
        found_ready = 1'b0;
        checks++; if ({done, exhausted, found_valid} !== 3'b100) begin failures++;
            $display("FAIL bp_ack got=%b exp=100", {done, exhausted, found_valid}); end
        kick(rnd256(), '0, 32'd0);
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL b2b_busy got=%0b exp=1", busy); end
        step_until(1, 20, at);
        checks++; if (at !== 2 || exhausted !== 1'b1) begin failures++;
            $display("FAIL b2b_done got=%0d/%0b exp=2/1", at, exhausted); end
    endtask

    task automatic test_wrap();
        int at;
        int ei;
        logic [255:0] t;
        t  = fhash('0) + 256'd1;
        ei = first_hit('1, t, 2);
        kick('1, t, 32'd2);
        @(posedge clk); #1;
        checks++; if (hash_nonce !== '1) begin failures++;
            $display("FAIL wr_nonce0 got=%0h exp=all-ones", hash_nonce); end
        @(posedge clk); #1;
        checks++; if (hash_nonce !== '0) begin failures++;
            $display("FAIL wr_nonce1 got=%0h exp=0", hash_nonce); end
        step_until(3, P + 20, at);
        checks++; if (at !== 2 + P + ei || found_nonce !== '1 + 256'(ei)) begin failures++;
            $display("FAIL wr_found got=%0d/%0h exp=%0d/%0h", at, found_nonce, 2 + P + ei, '1 + 256'(ei)); end
        found_ready = 1'b1;
        @(posedge clk); #1;
        found_ready = 1'b0;
    endtask

    task automatic test_abort();
        int at;
        kick(rnd256(), '1, 32'd100);
        repeat (29) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL ab_busy got=%0b exp=0", busy); end
        step_until(32, 250, at);
        checks++; if (at !== -1) begin failures++;
            $display("FAIL ab_silent got=%0d exp=-1", at); end
        kick('0, '1, 32'd5);
        step_until(1, P + 20, at);
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if ({found_valid, done, busy} !== 3'b000) begin failures++;
            $display("FAIL ab_found got=%b exp=000", {found_valid, done, busy}); end
        step_until(1, 100, at);
        checks++; if (at !== -1) begin failures++;
            $display("FAIL ab_found_silent got=%0d exp=-1", at); end
    endtask

    task automatic test_random();
        int at;
        int ei;
        int m;
        int mode;
        logic [255:0] b, t;
        for (int it = 0; it < 8; it++) begin
            b    = rnd256();
            m    = $urandom_range(1, 8);
            mode = $urandom_range(0, 2);
            if (mode == 0)      t = '0;
            else if (mode == 1) t = fhash(b + 256'($urandom_range(0, m - 1))) + 256'd1;
            else                t = rnd256();
            ei = first_hit(b, t, m);
            kick(b, t, 32'(m));
            repeat (2) @(posedge clk);
            @(negedge clk);
            start = 1'b1;
            base_nonce = ~b;
            @(posedge clk); #1;
            start = 1'b0;
            step_until(4, m + P + 20, at);
            if (ei >= 0) begin
                checks++;
                if (at !== 2 + P + ei || found_nonce !== b + 256'(ei)
                    || found_digest !== fhash(b + 256'(ei))) begin
                    failures++;
                    $display("FAIL rnd%0d_hit got=%0d/%0h exp=%0d/%0h",
                             it, at, found_nonce, 2 + P + ei, b + 256'(ei));
                end
                found_ready = 1'b1;
                @(posedge clk); #1;
                found_ready = 1'b0;
                checks++; if ({done, exhausted} !== 2'b10) begin failures++;
                    $display("FAIL rnd%0d_ack got=%b exp=10", it, {done, exhausted}); end
            end else begin
                checks++;
                if (at !== m + P + 2 || {done, exhausted, found_valid} !== 3'b110) begin
                    failures++;
                    $display("FAIL rnd%0d_miss got=%0d/%b exp=%0d/110",
                             it, at, {done, exhausted, found_valid}, m + P + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int at;
        kick(rnd256(), '1, 32'd50);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, exhausted, found_valid} !== 4'b0000) begin failures++;
            $display("FAIL rm_flags got=%b exp=0000", {busy, done, exhausted, found_valid}); end
        checks++; if (hash_nonce !== '0 || found_nonce !== '0 || found_digest !== '0) begin failures++;
            $display("FAIL rm_data got=%0h/%0h/%0h exp=0", hash_nonce, found_nonce, found_digest); end
        @(negedge clk) rst_n = 1'b1;
        step_until(1, 200, at);
        checks++; if (at !== -1 || busy !== 1'b0) begin failures++;
            $display("FAIL rm_silent got=%0d/%0b exp=-1/0", at, busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_hit();
        test_no_hit();
        test_max_zero();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nonce_search_ctrl.md
NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 65: cycles from a nonce presented on hash_nonce to its digest on hash_digest.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: single-cycle pulse; samples base_nonce, target, max_count in IDLE.
REQ-005 SHALL have port abort, input, 1: terminates any search immediately.
REQ-006 SHALL have port base_nonce, input, 256: first nonce of the search.
REQ-007 SHALL have port target, input, 256: a digest hits when it is unsigned strictly less than target.
REQ-008 SHALL have port max_count, input, 32: number of nonces to issue.
REQ-009 SHALL have port hash_nonce, output, 256: drives the hash stage input.
REQ-010 SHALL have port hash_digest, input, 256: hash stage output.
REQ-011 SHALL have ports found_valid (output, 1), found_ready (input, 1), found_nonce (output, 256), found_digest (output, 256): hit result with valid/ready handshake.
REQ-012 SHALL have ports busy, done, exhausted: outputs, 1 bit each.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, FOUND; busy=1 in every state except IDLE.
REQ-014 IDLE->RUN SHALL occur on start; idx clears to 0. start outside IDLE SHALL be ignored.
REQ-015 In RUN, each cycle with idx<max_count SHALL register hash_nonce=base_nonce+idx (mod 2^256), then increment idx; no-issue cycles SHALL leave hash_nonce unchanged.
REQ-016 A tag pipeline of depth PIPE_LAT SHALL carry {valid, idx} per issue cycle; tag valid=0 on no-issue cycles.
REQ-017 A nonce registered at edge t SHALL have its digest compared at edge t+PIPE_LAT, only when the emerging tag valid=1.
REQ-018 A hit in RUN or DRAIN SHALL capture found_nonce=base+tag idx and found_digest=hash_digest, raise found_valid on the next edge, enter FOUND, and stop issuing.
REQ-019 Only the first hit (lowest idx) SHALL be reported; results arriving in FOUND SHALL be discarded.
REQ-020 RUN->DRAIN SHALL occur when idx reaches max_count; DRAIN->IDLE with a one-cycle done=1 and exhausted=1 SHALL occur when no valid tag remains in flight.
REQ-021 max_count=0 SHALL give RUN->DRAIN->IDLE with no issue; done and exhausted pulse 2 cycles after start.
REQ-022 In FOUND, found_valid, found_nonce and found_digest SHALL stay stable until found_valid&found_ready; that cycle SHALL go to IDLE and pulse done=1 with exhausted=0.
REQ-023 exhausted SHALL hold its value until the next accepted start.
REQ-024 abort SHALL take priority over every other event: next state IDLE, all tag valids cleared, found_valid=0, done not pulsed.
REQ-025 Leaving FOUND or DRAIN SHALL clear all tag valid bits.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, idx=0, all tag valids 0, and hash_nonce, found_nonce, found_digest, found_valid, busy, done and exhausted all 0.
REQ-027 Reset mid-search SHALL discard all in-flight results; no found_valid or done SHALL follow reset release until a new start.

Structure
REQ-028 Package sha_mine_pkg SHALL hold the state enum, PIPE_LAT default, and WORD_W=32 and DIGEST_W=256 constants.
REQ-029 The tag delay line SHALL be the sub-module tag_pipe (parameters DEPTH, W; async active-low reset clears valids).

Verification
REQ-030 target=2^256-1, base=0, max_count=10, start at edge 0 -> hash_nonce=0 at edge 1; found_valid at edge 2+PIPE_LAT (67) with found_nonce=0.
REQ-031 target=0, base=5, max_count=4 -> nonces 5..8 issued; no found_valid; done and exhausted at edge 4+PIPE_LAT+2.
REQ-032 Hit, with found_ready held low 20 cycles -> found_valid and data stable throughout; done on the handshake edge; the next start is accepted.
REQ-033 abort at edge 30 of a max_count=100 search -> busy=0 at edge 31; no found_valid or done, even when earlier digests hit.
REQ-034 base=2^256-1, max_count=2 -> hash_nonce sequence is FF..FF then 0; a bench model hashing both gives the matching found_nonce for the first hit.
REQ-035 rst_n pulsed low mid-RUN -> all outputs 0 immediately (asynchronously); stay idle after release.
